// File: rtl/bpd_pkg.sv
// Shared branch-predictor update packet types.
// Field order follows the commit packet layout, meta_0 in the LSBs.
package bpd_pkg;

  localparam int BPD_UPDATE_W = 168;

  typedef struct packed {
    logic [15:0] old_history;
    logic        current_saw_branch_not_taken;
    logic        new_saw_branch_not_taken;
    logic        new_saw_branch_taken;
    logic [4:0]  ras_idx;
  } bpd_ghist_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] bits;
  } bpd_cfi_idx_t;

  typedef struct packed {
    logic         is_mispredict_update;
    logic         is_repair_update;
    logic [3:0]   btb_mispredicts;
    logic [39:0]  pc;
    logic [3:0]   br_mask;
    bpd_cfi_idx_t cfi_idx;
    logic         cfi_taken;
    logic         cfi_mispredicted;
    logic         cfi_is_br;
    logic         cfi_is_jal;
    logic         cfi_is_jalr;
    bpd_ghist_t   ghist;
    logic         lhist_0;
    logic [39:0]  target;
    logic [44:0]  meta_0;
  } bpd_update_t;

endpackage

// File: rtl/bpd_ptr_ctr.sv
// Wrap-bit queue pointer: increments mod 2*DEPTH, clears on flush.
module bpd_ptr_ctr #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bpd_update_queue.sv
// Commit-side FIFO feeding the low-priority predictor update port.
// Flush empties it in one cycle and counts discarded entries.
module bpd_update_queue
  import bpd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PKT_W = BPD_UPDATE_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_enq_valid,
  output logic                     io_enq_ready,
  input  logic [PKT_W-1:0]         io_enq_bits,
  output logic                     io_deq_valid,
  input  logic                     io_deq_ready,
  output logic [PKT_W-1:0]         io_deq_bits,
  input  logic                     io_flush,
  output logic [$clog2(DEPTH):0]   io_count,
  output logic [7:0]               io_drop_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]    head, tail;
  logic [PKT_W-1:0] mem_q [DEPTH];
  logic             empty, full;
  logic             enq_fire, deq_fire;
  logic [7:0]       drop_q, drop_d;
  logic [8:0]       drop_sum;

  assign empty = (head == tail);
  assign full  = (head[IW-1:0] == tail[IW-1:0])
              && (head[IW] != tail[IW]);

  assign io_enq_ready = ~full;
  assign io_deq_valid = ~empty;
  assign io_deq_bits  = mem_q[head[IW-1:0]];
  assign io_count     = tail - head;

  assign enq_fire = io_enq_valid & ~full;
  assign deq_fire = ~empty & io_deq_ready;

  bpd_ptr_ctr #(.W(PW)) u_tail (
    .clock (clock),
    .reset (reset),
    .inc_i (enq_fire & ~io_flush),
    .clr_i (io_flush),
    .ptr_o (tail)
  );

  bpd_ptr_ctr #(.W(PW)) u_head (
    .clock (clock),
    .reset (reset),
    .inc_i (deq_fire & ~io_flush),
    .clr_i (io_flush),
    .ptr_o (head)
  );

  always_ff @(posedge clock) begin
    if (reset && enq_fire && !io_flush)
      mem_q[tail[IW-1:0]] <= io_enq_bits;
  end

  // The head packet consumed in a flush cycle is handed off, not dropped.
  assign drop_sum = {1'b0, drop_q} + 9'(io_count) - 9'(deq_fire);

  always_comb begin
    drop_d = drop_q;
    if (io_flush)
      drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign io_drop_count = drop_q;

endmodule

// File: tb/tb_bpd_update_queue.sv
// Directed bench for bpd_update_queue with a packet scoreboard.
module tb_bpd_update_queue;
  import bpd_pkg::*;

  localparam int DEPTH = 4;
  localparam int W = BPD_UPDATE_W;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enq_v = 1'b0;
  logic         enq_r;
  logic [W-1:0] enq_b = '0;
  logic         deq_v;
  logic         deq_r = 1'b0;
  logic [W-1:0] deq_b;
  logic         flush = 1'b0;
  logic [2:0]   count;
  logic [7:0]   drop;

  int nchk = 0;
  int nerr = 0;

  bpd_update_t sb[$];
  int          drop_m = 0;

  always #5 clock = ~clock;

  bpd_update_queue #(.DEPTH(DEPTH), .PKT_W(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_enq_valid  (enq_v),
    .io_enq_ready  (enq_r),
    .io_enq_bits   (enq_b),
    .io_deq_valid  (deq_v),
    .io_deq_ready  (deq_r),
    .io_deq_bits   (deq_b),
    .io_flush      (flush),
    .io_count      (count),
    .io_drop_count (drop)
  );

  function automatic bpd_update_t mk(input logic [39:0] pc);
    logic [W-1:0] r;
    bpd_update_t  p;
    for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(0, 1));
    p = bpd_update_t'(r);
    p.pc = pc;
    return p;
  endfunction

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check pre-edge outputs, advance model.
  task automatic step(input logic       rst_n,
                      input logic       ev,
                      input logic [39:0] pc,
                      input logic       dr,
                      input logic       fl,
                      input logic       check);
    bpd_update_t p;
    bit ef, df;
    int sz;
    p = mk(pc);
    @(negedge clock);
    reset = rst_n;
    enq_v = ev;
    enq_b = p;
    deq_r = dr;
    flush = fl;
    #1;
    sz = sb.size();
    if (check) begin
      chk("enq_ready", W'(enq_r), W'(sz < DEPTH));
      chk("deq_valid", W'(deq_v), W'(sz != 0));
      chk("count", W'(count), W'(sz));
      chk("drop_count", W'(drop), W'(drop_m));
      if (sz != 0) chk("deq_bits", deq_b, sb[0]);
    end
    ef = ev && (sz < DEPTH);
    df = dr && (sz != 0);
    @(posedge clock);
    if (!rst_n) begin
      sb.delete();
      drop_m = 0;
    end else if (fl) begin
      drop_m = drop_m + sz - int'(df);
      if (drop_m > 255) drop_m = 255;
      sb.delete();
    end else begin
      if (df) void'(sb.pop_front());
      if (ef) sb.push_back(p);
    end
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);

    // ordered delivery, count peaks at 3
    step(1, 1, 40'h1000, 0, 0, 1);
    step(1, 1, 40'h1004, 0, 0, 1);
    step(1, 1, 40'h1008, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 1);

    // fill, reject 5th, then free a slot with enq held
    for (int i = 0; i < 5; i++)
      step(1, 1, 40'h1100 + 40'(i), 0, 0, 1);
    step(1, 1, 40'h1104, 1, 0, 1);
    step(1, 1, 40'h1104, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);

    // full with simultaneous enq+deq: enq refused
    step(1, 1, 40'h1200, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 1);

    // 3 entries, flush while head is consumed
    for (int i = 0; i < 3; i++)
      step(1, 1, 40'h1300 + 40'(i), 0, 0, 1);
    step(1, 1, 40'h13ff, 1, 1, 1);
    step(1, 1, 40'h2000, 0, 0, 1);
    step(1, 1, 40'h2004, 0, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1);

    // drop counter saturation
    for (int r = 0; r < 70; r++) begin
      for (int i = 0; i < 4; i++)
        step(1, 1, 40'h4000 + 40'(i), 0, 0, 1);
      step(1, 0, 0, 0, 1, 1);
    end
    step(1, 0, 0, 0, 0, 1);

    // wrapping random stream, reset mid-burst
    for (int i = 0; i < 24; i++)
      step(1, 1'($urandom_range(0, 1)), 40'h3000 + 40'(i),
           1'($urandom_range(0, 1)), 0, 1);
    step(1, 1, 40'h3100, 0, 0, 1);
    step(0, 1, 40'h3101, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 40'h3200, 0, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/bpd_update_queue.md
# bpd_update_queue

Circular FIFO buffering commit-time branch-predictor update packets ahead of the two-input update arbiter, whose port 1 (low priority, behind mispredict/repair updates) it drives. It absorbs bursts from commit while the arbiter favours port 0, supports a single-cycle flush on pipeline redirect, and reports occupancy and a saturating count of flushed packets.

## Interface
- DEPTH, 4, entry count; power of two, ≥2
- PKT_W, 168, update packet width (`bpd_update_t`)
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low: sampled 0 at a rising edge resets the block
- io_enq_valid  in  1  commit offers a packet
- io_enq_ready  out  1  queue accepts; equals !full
- io_enq_bits  in  PKT_W  packet (is_mispredict_update, is_repair_update, btb_mispredicts[3:0], pc[39:0], br_mask[3:0], cfi_idx {valid, bits[1:0]}, cfi_taken, cfi_mispredicted, cfi_is_br/jal/jalr, ghist {old_history[15:0], current_saw_branch_not_taken, new_saw_branch_not_taken, new_saw_branch_taken, ras_idx[4:0]}, lhist_0, target[39:0], meta_0[44:0])
- io_deq_valid  out  1  head entry present; to arbiter io_in_1_valid
- io_deq_ready  in  1  from arbiter io_in_1_ready
- io_deq_bits  out  PKT_W  head entry, fields as above
- io_flush  in  1  discard all entries
- io_count  out  log2(DEPTH)+1  current occupancy
- io_drop_count  out  8  saturating count of entries discarded by flush

## Operation
- Storage: DEPTH × PKT_W register array; head/tail pointers of log2(DEPTH)+1 bits (MSB = wrap bit). Empty: head==tail. Full: index bits equal, wrap bits differ.
- Enqueue fires when io_enq_valid & io_enq_ready: write io_enq_bits at tail, tail+1 (mod 2·DEPTH).
- Dequeue fires when io_deq_valid & io_deq_ready: head+1.
- io_deq_valid = !empty; io_deq_bits = entry[head index], combinational from array.
- io_count = tail − head, modulo 2·DEPTH, width log2(DEPTH)+1; never exceeds DEPTH.
- Flush: io_flush high → next cycle head=tail=0, count 0; any enq or deq fire in the flush cycle is ignored (enq not written, dequeued packet still counted as handed off, i.e. the arbiter's consumption stands). io_drop_count += (count − deq fire), saturating at 255.
- Simultaneous enq+deq, not full: both fire, count unchanged. When full, enq_ready=0 even if deq fires same cycle (no pass-through of freed slot).
- No payload inspection; packet ordering preserved strictly.

## Timing
- Reset values: head=tail=0, io_enq_ready=1, io_deq_valid=0, io_count=0, io_drop_count=0; array contents not reset, io_deq_bits don't-care while io_deq_valid=0.
- Enq-to-deq latency: 1 cycle (packet enqueued at edge N visible on io_deq_* after edge N). No combinational enq→deq bypass.
- io_enq_ready depends only on state (no path from io_deq_ready).
- io_deq_valid must not drop while io_deq_ready=0 except by flush or reset.
- Reset mid-burst: all pointers and counters return to reset values at that edge; in-flight enq dropped and not counted.

## Structure
- Shared package `bpd_pkg`: `bpd_update_t` packed struct (field order as listed, pc at named position, meta_0 LSBs last), `BPD_UPDATE_W = 168`, ghist sub-struct typedef.
- Single module; optional sub-module `bpd_ptr_ctr` (wrap-bit pointer increment/clear) instantiated twice.

## Test plan
- Reset then push 3 packets with pc 0x1000/0x1004/0x1008, deq_ready=1 from cycle 5 → deq order 0x1000,0x1004,0x1008; first deq_valid one cycle after first enq; count peaks 3.
- DEPTH=4, deq_ready=0, 5 enq attempts → 4 accepted, enq_ready=0 on 5th, count=4; then one deq with enq_valid held → enq_ready returns next cycle, 5th packet delivered last.
- Full queue, enq and deq same cycle → deq fires, enq rejected, count 3.
- 3 entries, flush with deq fire → count 0 next cycle, drop_count=2, subsequent packet 0x2000 is first out.
- Repeated flushes of 4 entries ×70 → drop_count saturates at 255.
- 10 wrap-around enq/deq cycles with random deq_ready, reset asserted (0) mid-stream → order preserved before reset; after reset count=0, deq_valid=0, drop_count=0.
